// File: rtl/ddi_link_pkg.sv
// Shared link-layer definitions for the DDI receiver and endpoint.
package ddi_link_pkg;
    localparam int DDI_FLIT_WIDTH   = 256;
    localparam int DDI_CREDIT_WIDTH = 4;

    typedef enum logic [1:0] {
        RX_INIT   = 2'd0,
        RX_ACTIVE = 2'd1,
        RX_ERROR  = 2'd2
    } rx_state_e;
endpackage

// File: rtl/ddi_sync_fifo.sv
// Synchronous receive buffer with flush; head entry read straight from storage registers.
module ddi_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/ddi_link_rx.sv
// Credit-based link receiver: parity check, receive buffer, credit return and error FSM.
module ddi_link_rx
    import ddi_link_pkg::*;
#(
    parameter int FLIT_WIDTH    = DDI_FLIT_WIDTH,
    parameter int FIFO_DEPTH    = 8,
    parameter int CREDIT_WIDTH  = DDI_CREDIT_WIDTH,
    parameter int CREDIT_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLIT_WIDTH-1:0]         lnk_flit,
    input  logic                          lnk_parity,
    input  logic                          lnk_valid,
    output logic [CREDIT_WIDTH-1:0]       crd_ret,
    output logic                          crd_ret_valid,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          par_err,
    output logic                          ovf_err,
    input  logic                          err_clr,
    output logic                          link_up,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CREDIT_WIDTH-1:0] DEPTH_CRD  = CREDIT_WIDTH'(FIFO_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] THRESH_CRD = CREDIT_WIDTH'(CREDIT_THRESH);

    rx_state_e                state, state_nxt;
    logic [CREDIT_WIDTH-1:0]  pending, pending_nxt, ret_q, ret_nxt;
    logic [CREDIT_WIDTH:0]    pend_sum;
    logic                     ret_vld_q, ret_vld_nxt, ret_now;
    logic                     par_err_nxt, ovf_err_nxt, par_drop;
    logic                     push, pop, flush, fifo_full, fifo_empty, parity_ok, init_grant;
    logic [CNT_W-1:0]         count;

    assign parity_ok = ((^lnk_flit) == lnk_parity);

    always_comb begin
        state_nxt   = state;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        par_drop    = 1'b0;
        ret_now     = 1'b0;
        ret_nxt     = '0;
        ret_vld_nxt = 1'b0;
        pend_sum    = '0;
        pending_nxt = pending;
        par_err_nxt = par_err;
        ovf_err_nxt = ovf_err;
        case (state)
            RX_INIT: begin
                pending_nxt = '0;
                state_nxt   = RX_ACTIVE;
            end
            RX_ACTIVE: begin
                pop = !fifo_empty && out_ready;
                if (lnk_valid) begin
                    if (!parity_ok) begin
                        par_drop    = 1'b1;
                        par_err_nxt = 1'b1;
                    end else if (fifo_full && !pop) begin
                        ovf_err_nxt = 1'b1;
                        state_nxt   = RX_ERROR;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (err_clr) par_err_nxt = 1'b0;
                // No return is launched on the overflow cycle; ERROR must stay silent
                ret_now = (state_nxt == RX_ACTIVE) &&
                          ((pending >= THRESH_CRD) || (pending != '0 && fifo_empty));
                if (ret_now) begin
                    ret_nxt     = pending;
                    ret_vld_nxt = 1'b1;
                end
                pend_sum = (ret_now ? '0 : {1'b0, pending}) +
                           (CREDIT_WIDTH+1)'(pop) + (CREDIT_WIDTH+1)'(par_drop);
                pending_nxt = (pend_sum > {1'b0, DEPTH_CRD}) ? DEPTH_CRD
                                                             : pend_sum[CREDIT_WIDTH-1:0];
            end
            RX_ERROR: begin
                if (err_clr) begin
                    flush       = 1'b1;
                    pending_nxt = '0;
                    par_err_nxt = 1'b0;
                    ovf_err_nxt = 1'b0;
                    state_nxt   = RX_INIT;
                end
            end
            default: state_nxt = RX_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_INIT;
            pending   <= '0;
            ret_q     <= '0;
            ret_vld_q <= 1'b0;
            par_err   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            ret_q     <= ret_nxt;
            ret_vld_q <= ret_vld_nxt;
            par_err   <= par_err_nxt;
            ovf_err   <= ovf_err_nxt;
        end
    end

    ddi_sync_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (lnk_flit),
        .dout  (out_flit),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // INIT grant is qualified by rst_n so nothing is advertised while held in reset
    assign init_grant    = (state == RX_INIT) && rst_n;
    assign crd_ret_valid = init_grant || ret_vld_q;
    assign crd_ret       = init_grant ? DEPTH_CRD : ret_q;
    assign link_up       = (state == RX_ACTIVE);
    assign out_valid     = link_up && !fifo_empty;
    assign rx_count      = count;
endmodule
